msg_upload_serializer: RTL and testbench

MSG_UPLOAD_SERIALIZER -- requirements
Module: msg_upload_serializer

---
 rtl/upload_pkg.sv | 24 ++
 rtl/sharer_pick.sv | 25 ++
 rtl/msg_upload_serializer.sv | 136 +++++++++++++
 tb/tb_msg_upload_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upload_pkg.sv
// Shared encodings for the message upload path: flit control codes,
// coherence command codes and the serializer state enum.
package upload_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'b00,
        CTRL_HEAD = 2'b01,
        CTRL_BODY = 2'b10,
        CTRL_TAIL = 2'b11
    } ctrl_e;

    typedef enum logic [4:0] {
        CMD_WBREQ    = 5'b00011,
        CMD_INVREQ   = 5'b00100,
        CMD_FLUSHREQ = 5'b00101,
        CMD_SCINVREQ = 5'b00110
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/sharer_pick.sv
// Lowest-set-bit priority encoder over the remaining sharer vector.
module sharer_pick #(
    parameter int NODES = 4,
    parameter int IDX_W = 2
) (
    input  logic [NODES-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = NODES - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_upload_serializer.sv
// Serializes a parallel coherence message into head/body/tail flits, replicating
// it once per sharer (with the head destination rewritten) for invalidations.
module msg_upload_serializer
    import upload_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 11,
    parameter int NODES     = 4,
    parameter int DEST_LSB  = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             msg_valid,
    output logic                             msg_ready,
    input  logic [FLIT_W*MAX_FLITS-1:0]      msg_flits,
    input  logic [$clog2(MAX_FLITS+1)-1:0]   msg_len,
    input  logic                             msg_multicast,
    input  logic [NODES-1:0]                 msg_inv_ids,
    output logic [FLIT_W-1:0]                out_flit,
    output logic [1:0]                       out_ctrl,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int LEN_W  = $clog2(MAX_FLITS + 1);
    localparam int IDX_W  = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
    localparam int DEST_W = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FLITS);

    state_e              r_state, w_state_next;
    logic [FLIT_W-1:0]   r_flit_mem [MAX_FLITS];
    logic [LEN_W-1:0]    r_len, r_idx, w_len_eff;
    logic                r_multicast;
    logic [NODES-1:0]    r_ids, w_ids_rest;
    logic [DEST_W-1:0]   w_node;
    logic                w_found, w_accept, w_fire, w_last, w_more;
    logic [FLIT_W-1:0]   w_flit;
    ctrl_e               w_ctrl;

    sharer_pick #(.NODES(NODES), .IDX_W(DEST_W)) u_pick (
        .i_vec   (r_ids),
        .o_idx   (w_node),
        .o_found (w_found)
    );

    assign w_accept = msg_valid && (r_state == ST_IDLE);
    assign w_fire   = (r_state == ST_SEND) && out_ready;
    assign w_last   = (r_idx == r_len - LEN_W'(1));
    assign w_more   = r_multicast && (|w_ids_rest);

    always_comb begin
        w_len_eff = msg_len;
        if (msg_len == '0)
            w_len_eff = LEN_W'(1);
        else if (msg_len > MAX_LEN)
            w_len_eff = MAX_LEN;
    end

    always_comb begin
        w_ids_rest = r_ids;
        if (w_found)
            w_ids_rest[w_node] = 1'b0;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && (!msg_multicast || (|msg_inv_ids)))
                         w_state_next = ST_SEND;
            ST_SEND: if (w_fire && w_last && !w_more)
                         w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_multicast <= 1'b0;
            r_ids       <= '0;
        end else if (w_accept) begin
            r_len       <= w_len_eff;
            r_idx       <= '0;
            r_multicast <= msg_multicast;
            r_ids       <= msg_multicast ? msg_inv_ids : '0;
        end else if (w_fire) begin
            if (w_last) begin
                r_idx <= '0;
                if (r_multicast)
                    r_ids <= w_ids_rest;
            end else begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    // NOTE: the payload buffer is deliberately not reset; it is only read in
    // SEND, which is reachable solely through a capture that overwrites it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < MAX_FLITS; k++)
                r_flit_mem[k] <= msg_flits[k*FLIT_W +: FLIT_W];
        end
    end

    always_comb begin
        w_flit = r_flit_mem[r_idx[IDX_W-1:0]];
        if (r_multicast && (r_idx == '0))
            w_flit[DEST_LSB +: DEST_W] = w_node;
        if (w_last)
            w_ctrl = CTRL_TAIL;
        else if (r_idx == '0)
            w_ctrl = CTRL_HEAD;
        else
            w_ctrl = CTRL_BODY;
    end

    // Outputs decode from state alone so an asynchronous reset idles them at once.
    assign out_valid = (r_state == ST_SEND);
    assign out_flit  = out_valid ? w_flit : '0;
    assign out_ctrl  = out_valid ? w_ctrl : CTRL_IDLE;
    assign msg_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_msg_upload_serializer.sv
// Scoreboard bench: a message-level model queues expected flits on issue,
// an independent monitor pops and compares on every output handshake.
module tb_msg_upload_serializer;

    localparam int FLIT_W    = 16;
    localparam int MAX_FLITS = 11;
    localparam int NODES     = 4;
    localparam int DEST_LSB  = 12;
    localparam int LEN_W     = $clog2(MAX_FLITS + 1);
    localparam int DEST_W    = 2;
    localparam int MSG_W     = FLIT_W * MAX_FLITS;

    typedef struct packed {
        logic [FLIT_W-1:0] flit;
        logic [1:0]        ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;

    logic               clk = 0;
    logic               rst = 1;
    logic               msg_valid = 0;
    logic               msg_ready;
    logic [MSG_W-1:0]   msg_flits = '0;
    logic [LEN_W-1:0]   msg_len = '0;
    logic               msg_multicast = 0;
    logic [NODES-1:0]   msg_inv_ids = '0;
    logic [FLIT_W-1:0]  out_flit;
    logic [1:0]         out_ctrl;
    logic               out_valid;
    logic               out_ready = 1;
    logic               busy;

    msg_upload_serializer #(
        .FLIT_W(FLIT_W), .MAX_FLITS(MAX_FLITS), .NODES(NODES), .DEST_LSB(DEST_LSB)
    ) dut (
        .clk(clk), .rst(rst),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_flits(msg_flits), .msg_len(msg_len),
        .msg_multicast(msg_multicast), .msg_inv_ids(msg_inv_ids),
        .out_flit(out_flit), .out_ctrl(out_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected flit stream from the message rules: clamp length, one copy per
    // sharer in ascending order (or one unmodified copy for unicast).
    function automatic int model_push(input logic [MSG_W-1:0] flits, input logic [LEN_W-1:0] len,
                                      input logic mc, input logic [NODES-1:0] ids);
        int n;
        int pushed = 0;
        n = (len == 0) ? 1 : ((int'(len) > MAX_FLITS) ? MAX_FLITS : int'(len));
        for (int node = 0; node < (mc ? NODES : 1); node++) begin
            if (mc && !ids[node]) continue;
            for (int k = 0; k < n; k++) begin
                exp_t e;
                e.flit = flits[k*FLIT_W +: FLIT_W];
                if (mc && k == 0) e.flit[DEST_LSB +: DEST_W] = DEST_W'(node);
                e.ctrl = (k == n - 1) ? 2'b11 : ((k == 0) ? 2'b01 : 2'b10);
                exp_q.push_back(e);
                pushed++;
            end
        end
        return pushed;
    endfunction

    task automatic issue(input logic [MSG_W-1:0] flits, input logic [LEN_W-1:0] len,
                         input logic mc, input logic [NODES-1:0] ids, output int nexp);
        int guard = 0;
        nexp = 0;
        while (!msg_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!msg_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=busy required=idle");
            return;
        end
        msg_flits = flits; msg_len = len; msg_multicast = mc; msg_inv_ids = ids;
        msg_valid = 1;
        nexp = model_push(flits, len, mc, ids);
        @(posedge clk); #1;
        msg_valid = 0;
        if (nexp > 0) check("first_valid", out_valid, 1);
        else          check("mc_zero_ready", msg_ready, 1);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!msg_ready && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!msg_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=%0d cycles required=idle", cycles);
        end
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each handshaken flit and checks held outputs during stalls.
    initial begin
        bit   held_v = 0;
        exp_t held;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
            end else begin
                check("no_bubble", out_valid, busy);
                if (out_valid) begin
                    if (held_v) begin
                        check("hold_flit", out_flit, held.flit);
                        check("hold_ctrl", out_ctrl, held.ctrl);
                    end
                    if (out_ready) begin
                        held_v = 0;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_flit actual=%0h/%0h required=none", out_flit, out_ctrl);
                        end else begin
                            e = exp_q.pop_front();
                            check("flit", out_flit, e.flit);
                            check("ctrl", out_ctrl, e.ctrl);
                        end
                    end else begin
                        held_v = 1;
                        held.flit = out_flit;
                        held.ctrl = out_ctrl;
                    end
                end
            end
        end
    end

    initial begin
        logic [MSG_W-1:0] f;
        int nexp;
        int cyc;

        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_flit", out_flit, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_ready", msg_ready, 1);

        // Unicast, three flits, full throughput.
        f = '0;
        f[0*FLIT_W +: FLIT_W] = 16'hA001;
        f[1*FLIT_W +: FLIT_W] = 16'hB002;
        f[2*FLIT_W +: FLIT_W] = 16'hC003;
        issue(f, 3, 0, 4'b0000, nexp);
        wait_idle(cyc);
        check("uni3_cycles", cyc, 3);

        // Multicast to nodes 1 and 3, two flits each, back-to-back.
        f = '0;
        f[1*FLIT_W +: FLIT_W] = 16'h5A5A;
        issue(f, 2, 1, 4'b1010, nexp);
        wait_idle(cyc);
        check("mc1010_cycles", cyc, 4);

        // Unicast four flits with a three-cycle stall on flit 1.
        f = '0;
        for (int k = 0; k < 4; k++) f[k*FLIT_W +: FLIT_W] = FLIT_W'(16'h7100 + k);
        issue(f, 4, 0, 4'b0000, nexp);
        @(posedge clk); #1;
        out_ready = 0;
        check("stall_ctrl", out_ctrl, 2'b10);
        check("stall_flit", out_flit, 16'h7101);
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
        wait_idle(cyc);
        check("stall_rest_cycles", cyc, 3);

        // Multicast with no sharers, then a zero-length unicast.
        f = '0;
        f[0*FLIT_W +: FLIT_W] = 16'h0F0F;
        issue(f, 3, 1, 4'b0000, nexp);
        repeat (3) @(posedge clk);
        #1 check("mc_zero_idle", msg_ready, 1);
        f[0*FLIT_W +: FLIT_W] = 16'h1234;
        issue(f, 0, 0, 4'b0000, nexp);
        wait_idle(cyc);
        check("len0_cycles", cyc, 1);

        // Over-length clamps to MAX_FLITS; one-flit copies to every node.
        for (int k = 0; k < MAX_FLITS; k++) f[k*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
        issue(f, 15, 0, 4'b0000, nexp);
        wait_idle(cyc);
        check("clamp_cycles", cyc, MAX_FLITS);
        issue(f, 1, 1, 4'b1111, nexp);
        wait_idle(cyc);
        check("mc_len1_cycles", cyc, 4);

        // Reset in the middle of a four-way multicast.
        for (int k = 0; k < MAX_FLITS; k++) f[k*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
        issue(f, 3, 1, 4'b1111, nexp);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_ctrl", out_ctrl, 0);
        check("abort_flit", out_flit, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1 check("abort_ready", msg_ready, 1);
        for (int k = 0; k < MAX_FLITS; k++) f[k*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
        issue(f, 5, 0, 4'b0000, nexp);
        wait_idle(cyc);
        check("after_abort_cycles", cyc, 5);

        // Randomized messages under random back-pressure.
        rand_ready = 1;
        for (int m = 0; m < 40; m++) begin
            for (int k = 0; k < MAX_FLITS; k++) f[k*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
            issue(f, LEN_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  NODES'($urandom), nexp);
        end
        wait_idle(cyc);
        rand_ready = 0;
        @(posedge clk); #1 out_ready = 1;
        repeat (3) @(posedge clk);
        #1 check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
